mem_lsu: RTL and testbench
==========================

MEM_LSU -- requirements
Module: mem_lsu

Interface
- REQ-001: Clocking SHALL be one clock; reset is synchronous and active-high.
- REQ-002: clk  input  1  pipeline clock; all state updates on rising edge.
- REQ-003: rst  input  1  synchronous reset, active-high.
- REQ-004: stall  input  6  pipeline stall vector; bit 4 = 1 means MEM/WB register holds.
- REQ-005: mem_waddr_i  input  5, mem_we_i  input  1, mem_wdata_i  input  32  destination, write-enable and ALU result from EX/MEM register.
- REQ-006: mem_aluop_i  input  5  operation; LB=5'h10, LBU=5'h11, LH=5'h12, LHU=5'h13, LW=5'h14, SB=5'h15, SH=5'h16, SW=5'h17; all other codes are non-memory.
- REQ-007: mem_addr_i  input  32  effective address; mem_reg2_i  input  32  store data.
- REQ-008: wb_waddr_o  output  5, wb_we_o  output  1, wb_wdata_o  output  32  result to MEM/WB register.
- REQ-009: stallreq_o  output  1  request to freeze stages 0-4.
- REQ-010: misalign_o  output  1  alignment fault flag for the current instruction.
- REQ-011: dbus_req_o  output  1, dbus_we_o  output  1, dbus_addr_o  output  32 (word-aligned, [1:0]=00), dbus_sel_o  output  4, dbus_wdata_o  output  32  registered data-bus request.
- REQ-012: dbus_rdata_i  input  32, dbus_ack_i  input  1  bus read data and single-cycle completion strobe.

Function
- REQ-013: FSM SHALL have states IDLE, BUSY, DONE.
- REQ-014: Non-memory op in IDLE SHALL pass wb_* = mem_*_i combinationally, stallreq_o=0, no bus activity.
- REQ-015: Aligned memory op in IDLE SHALL assert stallreq_o combinationally in that cycle and move to BUSY, with dbus_req_o=1 and dbus_addr_o/we/sel/wdata registered at that edge.
- REQ-016: Alignment: LH/LHU/SH need addr[0]=0; LW/SW need addr[1:0]=00; violation SHALL set misalign_o=1 combinationally, wb_we_o=0, no bus request, stallreq_o=0, remain IDLE.
- REQ-017: BUSY SHALL hold dbus_* stable and stallreq_o=1 until dbus_ack_i=1; on ack, dbus_req_o drops and state goes to DONE, capturing dbus_rdata_i.
- REQ-018: DONE SHALL drive stallreq_o=0 and present the captured result on wb_*; DONE->IDLE on the first cycle with stall[4]=0; stays DONE while stall[4]=1.
- REQ-019: Byte lanes big-endian: addr[1:0]=00 -> sel 1000 (bits 31:24), 01 -> 0100, 10 -> 0010, 11 -> 0001; halfword addr[1]=0 -> 1100, 1 -> 0011; word -> 1111.
- REQ-020: Store data: SB = {4{reg2[7:0]}}, SH = {2{reg2[15:0]}}, SW = reg2; dbus_we_o=1 for stores, 0 for loads.
- REQ-021: Loads: selected lane extracted; LB/LH sign-extend, LBU/LHU zero-extend, LW full word; result on wb_wdata_o, wb_we_o=mem_we_i.
- REQ-022: Stores: wb_wdata_o=mem_wdata_i, wb_we_o=mem_we_i.
- REQ-023: dbus_ack_i SHALL be ignored in IDLE and DONE.
- REQ-024: Latency: memory op with ack on first BUSY cycle SHALL complete in 2 cycles (IDLE, BUSY) with result valid in DONE.

Reset
- REQ-025: rst=1 SHALL force state IDLE, dbus_req_o=0, dbus_we_o=0, dbus_addr_o=0, dbus_sel_o=0, dbus_wdata_o=0, captured data=0 at the next edge.
- REQ-026: Reset during BUSY SHALL abandon the access; a later ack SHALL be ignored.
- REQ-027: While rst=1, stallreq_o=0, misalign_o=0, wb_we_o=0, wb_waddr_o=0, wb_wdata_o=0.

Verification
- REQ-028: LB addr=0x1001, rdata=0x11F23344, ack next cycle -> sel=0100, wb_wdata_o=0xFFFFFFF2, stallreq_o high for 2 cycles.
- REQ-029: SH addr=0x2002, reg2=0x0000ABCD -> dbus_we_o=1, sel=0011, dbus_wdata_o=0xABCDABCD, addr=0x2000.
- REQ-030: LW addr=0x3002 -> misalign_o=1, wb_we_o=0, dbus_req_o never asserted, stallreq_o=0.
- REQ-031: LHU addr=0x40, ack delayed 5 cycles, rdata=0x8001xxxx -> dbus_* stable for 5 cycles, wb_wdata_o=0x00008001.
- REQ-032: Load completes with stall[4]=1 held 3 cycles -> state DONE for 3 cycles, wb_* stable, stallreq_o=0, IDLE after release.
- REQ-033: rst asserted in BUSY, ack arrives 1 cycle later -> dbus_req_o=0, state IDLE, no wb_we_o pulse.

Source files
------------

// File: rtl/mem_lsu.sv
// ============================================================================
//  Module      : mem_lsu
//  Description : Memory-stage load/store unit. Issues a single registered
//                data-bus request per memory instruction, freezes the
//                pipeline until the bus acknowledges, then presents the
//                load/store result to the MEM/WB register.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic [4:0]  mem_waddr_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [4:0]  mem_aluop_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_reg2_i,
    output logic [4:0]  wb_waddr_o,
    output logic        wb_we_o,
    output logic [31:0] wb_wdata_o,
    output logic        stallreq_o,
    output logic        misalign_o,
    output logic        dbus_req_o,
    output logic        dbus_we_o,
    output logic [31:0] dbus_addr_o,
    output logic [3:0]  dbus_sel_o,
    output logic [31:0] dbus_wdata_o,
    input  logic [31:0] dbus_rdata_i,
    input  logic        dbus_ack_i
);

    localparam logic [4:0] OP_LB  = 5'h10;
    localparam logic [4:0] OP_LBU = 5'h11;
    localparam logic [4:0] OP_LH  = 5'h12;
    localparam logic [4:0] OP_LHU = 5'h13;
    localparam logic [4:0] OP_LW  = 5'h14;
    localparam logic [4:0] OP_SB  = 5'h15;
    localparam logic [4:0] OP_SH  = 5'h16;
    localparam logic [4:0] OP_SW  = 5'h17;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [4:0]  r_op;
    logic [1:0]  r_lane;
    logic [4:0]  r_waddr;
    logic        r_we;
    logic [31:0] r_alu;
    logic [31:0] r_result;

    logic        w_is_mem;
    logic        w_is_store;
    logic        w_misalign;
    logic [3:0]  w_sel;
    logic [31:0] w_store_data;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_val;
    logic        w_unused;

    // Only the MEM/WB hold bit of the stall vector matters here.
    assign w_unused = &{1'b0, stall[5], stall[3:0]};

    // Decode the incoming instruction: lane select, store data, alignment.
    always_comb begin
        w_is_mem     = (mem_aluop_i[4:3] == 2'b10);
        w_is_store   = 1'b0;
        w_misalign   = 1'b0;
        w_sel        = 4'b0000;
        w_store_data = 32'h0;
        case (mem_aluop_i)
            OP_LB, OP_LBU, OP_SB: begin
                w_sel        = 4'b1000 >> mem_addr_i[1:0];
                w_store_data = {4{mem_reg2_i[7:0]}};
                w_is_store   = (mem_aluop_i == OP_SB);
            end
            OP_LH, OP_LHU, OP_SH: begin
                w_sel        = mem_addr_i[1] ? 4'b0011 : 4'b1100;
                w_store_data = {2{mem_reg2_i[15:0]}};
                w_is_store   = (mem_aluop_i == OP_SH);
                w_misalign   = mem_addr_i[0];
            end
            OP_LW, OP_SW: begin
                w_sel        = 4'b1111;
                w_store_data = mem_reg2_i;
                w_is_store   = (mem_aluop_i == OP_SW);
                w_misalign   = (mem_addr_i[1:0] != 2'b00);
            end
            default: ;
        endcase
    end

    // Extract the addressed big-endian lane of the returning bus word.
    always_comb begin
        case (r_lane)
            2'd0:    w_byte = dbus_rdata_i[31:24];
            2'd1:    w_byte = dbus_rdata_i[23:16];
            2'd2:    w_byte = dbus_rdata_i[15:8];
            default: w_byte = dbus_rdata_i[7:0];
        endcase
        w_half = r_lane[1] ? dbus_rdata_i[15:0] : dbus_rdata_i[31:16];
        case (r_op)
            OP_LB:   w_load_val = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  w_load_val = {24'h0, w_byte};
            OP_LH:   w_load_val = {{16{w_half[15]}}, w_half};
            OP_LHU:  w_load_val = {16'h0, w_half};
            OP_LW:   w_load_val = dbus_rdata_i;
            default: w_load_val = r_alu;
        endcase
    end

    // Access sequencer: issue, wait for ack, hold result until MEM/WB advances.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_op         <= 5'h0;
            r_lane       <= 2'b00;
            r_waddr      <= 5'h0;
            r_we         <= 1'b0;
            r_alu        <= 32'h0;
            r_result     <= 32'h0;
            dbus_req_o   <= 1'b0;
            dbus_we_o    <= 1'b0;
            dbus_addr_o  <= 32'h0;
            dbus_sel_o   <= 4'b0000;
            dbus_wdata_o <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_is_mem && !w_misalign) begin
                        r_state      <= S_BUSY;
                        r_op         <= mem_aluop_i;
                        r_lane       <= mem_addr_i[1:0];
                        r_waddr      <= mem_waddr_i;
                        r_we         <= mem_we_i;
                        r_alu        <= mem_wdata_i;
                        dbus_req_o   <= 1'b1;
                        dbus_we_o    <= w_is_store;
                        dbus_addr_o  <= {mem_addr_i[31:2], 2'b00};
                        dbus_sel_o   <= w_sel;
                        dbus_wdata_o <= w_store_data;
                    end
                end
                S_BUSY: begin
                    if (dbus_ack_i) begin
                        r_state    <= S_DONE;
                        dbus_req_o <= 1'b0;
                        r_result   <= w_load_val;
                    end
                end
                S_DONE: begin
                    if (!stall[4]) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Write-back / stall / fault outputs; all forced quiet while in reset.
    always_comb begin
        wb_waddr_o = 5'h0;
        wb_we_o    = 1'b0;
        wb_wdata_o = 32'h0;
        stallreq_o = 1'b0;
        misalign_o = 1'b0;
        if (!rst) begin
            case (r_state)
                S_IDLE: begin
                    wb_waddr_o = mem_waddr_i;
                    if (!w_is_mem) begin
                        wb_we_o    = mem_we_i;
                        wb_wdata_o = mem_wdata_i;
                    end else if (w_misalign) begin
                        misalign_o = 1'b1;
                        wb_wdata_o = mem_wdata_i;
                    end else begin
                        stallreq_o = 1'b1;
                    end
                end
                S_BUSY: stallreq_o = 1'b1;
                S_DONE: begin
                    wb_waddr_o = r_waddr;
                    wb_we_o    = r_we;
                    wb_wdata_o = r_result;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_lsu.sv
// ============================================================================
//  Module      : tb_mem_lsu
//  Description : Self-checking bench for mem_lsu with a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic [4:0]  mem_waddr_i;
    logic        mem_we_i;
    logic [31:0] mem_wdata_i;
    logic [4:0]  mem_aluop_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_reg2_i;
    logic [4:0]  wb_waddr_o;
    logic        wb_we_o;
    logic [31:0] wb_wdata_o;
    logic        stallreq_o;
    logic        misalign_o;
    logic        dbus_req_o;
    logic        dbus_we_o;
    logic [31:0] dbus_addr_o;
    logic [3:0]  dbus_sel_o;
    logic [31:0] dbus_wdata_o;
    logic [31:0] dbus_rdata_i;
    logic        dbus_ack_i;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_lsu dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .mem_waddr_i  (mem_waddr_i),
        .mem_we_i     (mem_we_i),
        .mem_wdata_i  (mem_wdata_i),
        .mem_aluop_i  (mem_aluop_i),
        .mem_addr_i   (mem_addr_i),
        .mem_reg2_i   (mem_reg2_i),
        .wb_waddr_o   (wb_waddr_o),
        .wb_we_o      (wb_we_o),
        .wb_wdata_o   (wb_wdata_o),
        .stallreq_o   (stallreq_o),
        .misalign_o   (misalign_o),
        .dbus_req_o   (dbus_req_o),
        .dbus_we_o    (dbus_we_o),
        .dbus_addr_o  (dbus_addr_o),
        .dbus_sel_o   (dbus_sel_o),
        .dbus_wdata_o (dbus_wdata_o),
        .dbus_rdata_i (dbus_rdata_i),
        .dbus_ack_i   (dbus_ack_i)
    );

    // ---------------- reference model ----------------
    function automatic bit m_is_mem(input logic [4:0] op);
        return (op >= 5'h10) && (op <= 5'h17);
    endfunction

    function automatic bit m_is_store(input logic [4:0] op);
        return (op >= 5'h15) && (op <= 5'h17);
    endfunction

    function automatic int m_size(input logic [4:0] op);
        case (op)
            5'h10, 5'h11, 5'h15: return 1;
            5'h12, 5'h13, 5'h16: return 2;
            default:             return 4;
        endcase
    endfunction

    function automatic logic [31:0] m_mask(input int sz);
        return (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
    endfunction

    function automatic bit m_misaligned(input logic [4:0] op, input logic [31:0] addr);
        return (addr % m_size(op)) != 0;
    endfunction

    function automatic logic [3:0] m_sel(input logic [4:0] op, input logic [31:0] addr);
        int sz   = m_size(op);
        int lane = int'(addr % 4);
        return 4'(((1 << sz) - 1) << (4 - sz - lane));
    endfunction

    function automatic logic [31:0] m_store_data(input logic [4:0] op, input logic [31:0] reg2);
        int sz = m_size(op);
        logic [31:0] d = 32'h0;
        for (int i = 0; i < 4 / sz; i++) d |= (reg2 & m_mask(sz)) << (8 * sz * i);
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [4:0] op, input logic [31:0] addr,
                                           input logic [31:0] rdata);
        int sz   = m_size(op);
        int lane = int'(addr % 4);
        logic [31:0] v = (rdata >> (8 * (4 - sz - lane))) & m_mask(sz);
        if ((op == 5'h10 || op == 5'h12) && v[8 * sz - 1]) v |= ~m_mask(sz);
        return v;
    endfunction

    // ---------------- timing helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_nop();
        mem_aluop_i = 5'h00;
        mem_we_i    = 1'b0;
        mem_waddr_i = 5'h0;
        mem_wdata_i = 32'h0;
        mem_addr_i  = 32'h0;
        mem_reg2_i  = 32'h0;
    endtask

    // One complete aligned memory access with a given ack delay and DONE hold.
    task automatic run_mem_op(input string name, input logic [4:0] op, input logic [31:0] addr,
                              input logic [31:0] reg2, input logic [31:0] alu,
                              input logic [4:0] waddr, input logic we,
                              input logic [31:0] rdata, input int ack_delay, input int hold);
        logic [70:0] e_bus;
        logic [37:0] e_wb;
        logic [31:0] e_res;
        e_res = m_is_store(op) ? alu : m_load(op, addr, rdata);
        e_bus = {1'b1, m_is_store(op), addr & 32'hFFFF_FFFC, m_sel(op, addr), m_store_data(op, reg2)};
        e_wb  = {we, waddr, e_res};
        mem_aluop_i = op; mem_addr_i = addr; mem_reg2_i = reg2;
        mem_wdata_i = alu; mem_waddr_i = waddr; mem_we_i = we;
        dbus_ack_i = 1'b0; stall = 6'h0;
        #1;
        n_tests++;
        if ({stallreq_o, misalign_o, wb_we_o} !== 3'b100)
            $display("FAIL %s issue: stallreq/misalign/wb_we=%b expected 100", name,
                     {stallreq_o, misalign_o, wb_we_o});
        if ({stallreq_o, misalign_o, wb_we_o} !== 3'b100) n_fail++;
        tick();
        for (int c = 0; c <= ack_delay; c++) begin
            n_tests++;
            if ({dbus_req_o, dbus_we_o, dbus_addr_o, dbus_sel_o, dbus_wdata_o} !== e_bus) begin
                n_fail++;
                $display("FAIL %s busy%0d bus: got req=%b we=%b addr=%h sel=%b wd=%h expected %h",
                         name, c, dbus_req_o, dbus_we_o, dbus_addr_o, dbus_sel_o, dbus_wdata_o, e_bus);
            end
            n_tests++;
            if ({stallreq_o, wb_we_o} !== 2'b10) begin
                n_fail++;
                $display("FAIL %s busy%0d stall: stallreq/wb_we=%b expected 10", name, c,
                         {stallreq_o, wb_we_o});
            end
            if (c == ack_delay) begin
                dbus_ack_i = 1'b1;
                dbus_rdata_i = rdata;
            end
            tick();
        end
        dbus_ack_i = 1'b0;
        dbus_rdata_i = $urandom;
        for (int d = 1; d <= hold; d++) begin
            n_tests++;
            if ({dbus_req_o, stallreq_o} !== 2'b00) begin
                n_fail++;
                $display("FAIL %s done%0d: req/stallreq=%b expected 00", name, d,
                         {dbus_req_o, stallreq_o});
            end
            n_tests++;
            if ({wb_we_o, wb_waddr_o, wb_wdata_o} !== e_wb) begin
                n_fail++;
                $display("FAIL %s done%0d wb: got we=%b waddr=%0d wdata=%h expected we=%b waddr=%0d wdata=%h",
                         name, d, wb_we_o, wb_waddr_o, wb_wdata_o, we, waddr, e_res);
            end
            dbus_ack_i = 1'($urandom_range(0, 1));
            stall[4]   = (d < hold);
            if (d == hold) set_nop();
            tick();
        end
        dbus_ack_i = 1'b0;
        stall = 6'h0;
        mem_wdata_i = 32'h1234_5678; mem_waddr_i = 5'd9;
        #1;
        n_tests++;
        if ({stallreq_o, dbus_req_o, wb_we_o, wb_waddr_o, wb_wdata_o} !== {3'b000, 5'd9, 32'h1234_5678}) begin
            n_fail++;
            $display("FAIL %s idle after: stallreq=%b req=%b wb_we=%b waddr=%0d wdata=%h expected 0 0 0 9 12345678",
                     name, stallreq_o, dbus_req_o, wb_we_o, wb_waddr_o, wb_wdata_o);
        end
    endtask

    // Misaligned access must be flagged, not written back, and never hit the bus.
    task automatic check_misalign(input string name, input logic [4:0] op, input logic [31:0] addr);
        mem_aluop_i = op; mem_addr_i = addr; mem_we_i = 1'b1;
        mem_waddr_i = 5'd3; mem_reg2_i = $urandom; mem_wdata_i = $urandom;
        #1;
        n_tests++;
        if ({misalign_o, wb_we_o, stallreq_o} !== 3'b100) begin
            n_fail++;
            $display("FAIL %s flag: misalign/wb_we/stallreq=%b expected 100", name,
                     {misalign_o, wb_we_o, stallreq_o});
        end
        for (int i = 0; i < 2; i++) begin
            dbus_ack_i = 1'b1;
            tick();
            n_tests++;
            if ({dbus_req_o, misalign_o, stallreq_o} !== 3'b010) begin
                n_fail++;
                $display("FAIL %s hold%0d: req/misalign/stallreq=%b expected 010", name, i,
                         {dbus_req_o, misalign_o, stallreq_o});
            end
        end
        dbus_ack_i = 1'b0;
        set_nop();
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; stall = 6'h0; dbus_ack_i = 1'b0; dbus_rdata_i = 32'h0;
        mem_aluop_i = 5'h14; mem_addr_i = 32'h3002; mem_we_i = 1'b1;
        mem_waddr_i = 5'd7; mem_wdata_i = 32'hDEAD_BEEF; mem_reg2_i = 32'h55;
        tick(); tick();
        n_tests++;
        if ({dbus_req_o, dbus_we_o, dbus_addr_o, dbus_sel_o, dbus_wdata_o} !== 71'h0) begin
            n_fail++;
            $display("FAIL reset bus: req=%b we=%b addr=%h sel=%b wd=%h expected all 0",
                     dbus_req_o, dbus_we_o, dbus_addr_o, dbus_sel_o, dbus_wdata_o);
        end
        n_tests++;
        if ({stallreq_o, misalign_o, wb_we_o, wb_waddr_o, wb_wdata_o} !== 40'h0) begin
            n_fail++;
            $display("FAIL reset outputs: stallreq=%b misalign=%b we=%b waddr=%0d wdata=%h expected 0",
                     stallreq_o, misalign_o, wb_we_o, wb_waddr_o, wb_wdata_o);
        end
        mem_addr_i = 32'h3000;
        #1;
        n_tests++;
        if (stallreq_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset stallreq aligned: got %b expected 0", stallreq_o);
        end
        set_nop();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_nonmem();
        logic [4:0] op;
        for (int i = 0; i < 10; i++) begin
            do op = 5'($urandom_range(0, 31)); while (m_is_mem(op));
            mem_aluop_i = op; mem_waddr_i = 5'($urandom); mem_we_i = 1'($urandom);
            mem_wdata_i = $urandom; mem_addr_i = $urandom; mem_reg2_i = $urandom;
            dbus_ack_i = 1'($urandom);
            #1;
            n_tests++;
            if ({wb_we_o, wb_waddr_o, wb_wdata_o, stallreq_o, misalign_o} !==
                {mem_we_i, mem_waddr_i, mem_wdata_i, 2'b00}) begin
                n_fail++;
                $display("FAIL nonmem op=%h: we=%b waddr=%0d wdata=%h stall=%b mis=%b expected %b %0d %h 0 0",
                         op, wb_we_o, wb_waddr_o, wb_wdata_o, stallreq_o, misalign_o,
                         mem_we_i, mem_waddr_i, mem_wdata_i);
            end
            tick();
            n_tests++;
            if (dbus_req_o !== 1'b0) begin
                n_fail++;
                $display("FAIL nonmem op=%h bus: req=%b expected 0", op, dbus_req_o);
            end
        end
        dbus_ack_i = 1'b0;
        set_nop();
        #1;
    endtask

    task automatic test_examples();
        run_mem_op("lb_1001", 5'h10, 32'h1001, 32'h0, 32'h1001, 5'd4, 1'b1, 32'h11F2_3344, 0, 1);
        run_mem_op("sh_2002", 5'h16, 32'h2002, 32'h0000_ABCD, 32'h2002, 5'd0, 1'b0, 32'hFFFF_FFFF, 0, 1);
        run_mem_op("lhu_40_delay5", 5'h13, 32'h40, 32'h0, 32'h40, 5'd12, 1'b1, 32'h8001_5A5A, 5, 1);
        run_mem_op("lw_hold3", 5'h14, 32'h5004, 32'h0, 32'h5004, 5'd31, 1'b1, 32'hCAFE_F00D, 1, 3);
        run_mem_op("lb_neg", 5'h10, 32'h7003, 32'h0, 32'h0, 5'd1, 1'b1, 32'h0000_0080, 0, 1);
        run_mem_op("lh_neg", 5'h12, 32'h7002, 32'h0, 32'h0, 5'd2, 1'b1, 32'h0000_8123, 2, 2);
        run_mem_op("sb_3", 5'h15, 32'h9003, 32'h1234_56A7, 32'h9003, 5'd5, 1'b1, 32'h0, 0, 1);
        run_mem_op("sw", 5'h17, 32'hA000, 32'h89AB_CDEF, 32'hA000, 5'd6, 1'b0, 32'h0, 3, 2);
    endtask

    task automatic test_misalign();
        check_misalign("lw_3002", 5'h14, 32'h3002);
        check_misalign("lh_odd", 5'h12, 32'h0101);
        check_misalign("lhu_odd", 5'h13, 32'h0103);
        check_misalign("sh_odd", 5'h16, 32'h0201);
        check_misalign("sw_1", 5'h17, 32'h0401);
    endtask

    task automatic test_reset_busy();
        mem_aluop_i = 5'h14; mem_addr_i = 32'h0100; mem_we_i = 1'b1; mem_waddr_i = 5'd8;
        #1;
        tick();
        n_tests++;
        if (dbus_req_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rstbusy start: req=%b expected 1", dbus_req_o);
        end
        rst = 1'b1;
        tick();
        n_tests++;
        if ({dbus_req_o, dbus_we_o, dbus_addr_o, dbus_sel_o, dbus_wdata_o} !== 71'h0) begin
            n_fail++;
            $display("FAIL rstbusy bus: req=%b addr=%h sel=%b expected 0", dbus_req_o, dbus_addr_o, dbus_sel_o);
        end
        rst = 1'b0;
        set_nop();
        dbus_ack_i = 1'b1; dbus_rdata_i = 32'h7777_7777;
        #1;
        n_tests++;
        if ({wb_we_o, stallreq_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL rstbusy late ack: wb_we/stallreq=%b expected 00", {wb_we_o, stallreq_o});
        end
        tick();
        dbus_ack_i = 1'b0;
        n_tests++;
        if ({dbus_req_o, stallreq_o, wb_we_o, wb_wdata_o} !== 35'h0) begin
            n_fail++;
            $display("FAIL rstbusy after ack: req=%b stallreq=%b wb_we=%b wdata=%h expected 0",
                     dbus_req_o, stallreq_o, wb_we_o, wb_wdata_o);
        end
        run_mem_op("after_rst", 5'h11, 32'h0102, 32'h0, 32'h0, 5'd10, 1'b1, 32'h00C3_0000, 0, 1);
    endtask

    task automatic test_random();
        logic [4:0]  op;
        logic [31:0] addr;
        for (int i = 0; i < 30; i++) begin
            op   = 5'($urandom_range(16, 23));
            addr = $urandom;
            if (m_misaligned(op, addr))
                check_misalign("rand_mis", op, addr);
            else
                run_mem_op("rand", op, addr, $urandom, $urandom, 5'($urandom), 1'($urandom),
                           $urandom, $urandom_range(0, 4), $urandom_range(1, 3));
        end
    endtask

    initial begin
        rst = 1'b1;
        set_nop();
        stall = 6'h0;
        dbus_ack_i = 1'b0;
        dbus_rdata_i = 32'h0;
        test_reset();
        test_nonmem();
        test_examples();
        test_misalign();
        test_reset_busy();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
